// File: rtl/sd_cmd_seq.sv
// sd_cmd_seq: sequences one disk-controller transfer request onto the SD
// driver's register port. It writes base, sector, count and the command word
// on four consecutive cycles. It then polls the status register until the card
// reports completion or error, or until the timeout counter expires.
//
// Ports
//   clk, rst_n          single clock, synchronous active-low reset
//   req_valid/ready     request handshake (ready only while idle)
//   req_write           1 = memory-to-card (cmd 3), 0 = card-to-memory (cmd 2)
//   req_sector/count    starting sector and sector count
//   req_base            memory base address for the data master
//   done, done_err      one-cycle completion pulse and its error flag
//   avm_*               register port of the SD driver (no waitrequest,
//                       readdata valid exactly one cycle after avm_read)
module sd_cmd_seq #(
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd16777215,
    parameter int          POLL_GAP       = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [23:0] req_sector,
    input  logic [7:0]  req_count,
    input  logic [31:0] req_base,
    output logic        done,
    output logic        done_err,
    output logic [1:0]  avm_address,
    output logic        avm_write,
    output logic [31:0] avm_writedata,
    output logic        avm_read,
    input  logic [31:0] avm_readdata
);

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_WR_BASE   = 4'd1;
    localparam logic [3:0] S_WR_SECT   = 4'd2;
    localparam logic [3:0] S_WR_CNT    = 4'd3;
    localparam logic [3:0] S_WR_CMD    = 4'd4;
    localparam logic [3:0] S_POLL_RD   = 4'd5;
    localparam logic [3:0] S_POLL_WAIT = 4'd6;
    localparam logic [3:0] S_GAP       = 4'd7;
    localparam logic [3:0] S_FIN       = 4'd8;

    // Decoded meaning of the low three status bits
    localparam logic [1:0] DEC_IDLE = 2'd0;
    localparam logic [1:0] DEC_BUSY = 2'd1;
    localparam logic [1:0] DEC_ERR  = 2'd2;
    localparam logic [1:0] DEC_RDY  = 2'd3;

    // Last value of the gap counter; with POLL_GAP == 0 the GAP state is skipped
    localparam logic [15:0] GAP_LAST = (POLL_GAP > 1) ? 16'(POLL_GAP - 1) : 16'd0;

    // Map a raw driver status code onto the sequencer's four outcomes.
    // Codes 6 and 7 are undefined in the driver and are treated as errors.
    function automatic logic [1:0] decode_status(input logic [2:0] st);
        logic [1:0] res;
        case (st)
            3'd0:       res = DEC_IDLE;
            3'd2:       res = DEC_RDY;
            3'd3, 3'd4: res = DEC_BUSY;
            default:    res = DEC_ERR;
        endcase
        return res;
    endfunction

    logic [3:0]  state_r, state_s;
    logic        ready_r, ready_s;
    logic        done_r, done_s;
    logic        done_err_r, done_err_s;
    logic [1:0]  addr_r, addr_s;
    logic        wr_r, wr_s;
    logic [31:0] wdata_r, wdata_s;
    logic        rd_r, rd_s;
    logic        busy_r, busy_s;
    logic        two_r, two_s;
    logic [23:0] tmo_r, tmo_s;
    logic [15:0] gap_r, gap_s;
    logic        req_wr_r;
    logic [23:0] sect_r;
    logic [7:0]  cnt_r;
    logic [31:0] base_r;
    logic        hs_s;
    logic        tmo_hit_s;
    logic [1:0]  dec_s;
    logic        unused_s;

    assign hs_s      = (state_r == S_IDLE) & req_valid & ready_r;
    assign tmo_hit_s = (tmo_r >= TIMEOUT_CYCLES);
    assign dec_s     = decode_status(avm_readdata[2:0]);
    assign unused_s  = ^avm_readdata[31:3];

    assign req_ready     = ready_r;
    assign done          = done_r;
    assign done_err      = done_err_r;
    assign avm_address   = addr_r;
    assign avm_write     = wr_r;
    assign avm_writedata = wdata_r;
    assign avm_read      = rd_r;

    // Next-state and next-output computation; all outputs are registered,
    // so strobes are decided on the transition into the state that shows them.
    always_comb begin
        state_s    = state_r;
        ready_s    = 1'b0;
        done_s     = 1'b0;
        done_err_s = 1'b0;
        addr_s     = 2'd0;
        wr_s       = 1'b0;
        wdata_s    = 32'd0;
        rd_s       = 1'b0;
        busy_s     = busy_r;
        two_s      = two_r;
        gap_s      = gap_r;
        // Saturating so that the maximum TIMEOUT_CYCLES is still reachable
        tmo_s      = (tmo_r == 24'hFFFFFF) ? tmo_r : tmo_r + 24'd1;

        case (state_r)
            S_IDLE: begin
                if (hs_s) begin
                    if (req_count == 8'd0) begin
                        state_s    = S_FIN;
                        done_s     = 1'b1;
                        done_err_s = 1'b1;
                    end else begin
                        state_s = S_WR_BASE;
                        wr_s    = 1'b1;
                        addr_s  = 2'd0;
                        wdata_s = req_base;
                    end
                end else begin
                    ready_s = 1'b1;
                end
            end
            S_WR_BASE: begin
                state_s = S_WR_SECT;
                wr_s    = 1'b1;
                addr_s  = 2'd1;
                wdata_s = {8'd0, sect_r};
            end
            S_WR_SECT: begin
                state_s = S_WR_CNT;
                wr_s    = 1'b1;
                addr_s  = 2'd2;
                wdata_s = {24'd0, cnt_r};
            end
            S_WR_CNT: begin
                state_s = S_WR_CMD;
                wr_s    = 1'b1;
                addr_s  = 2'd3;
                wdata_s = req_wr_r ? 32'd3 : 32'd2;
            end
            S_WR_CMD: begin
                state_s = S_POLL_RD;
                rd_s    = 1'b1;
                tmo_s   = 24'd0;
            end
            S_POLL_RD: begin
                if (tmo_hit_s) begin
                    state_s    = S_FIN;
                    done_s     = 1'b1;
                    done_err_s = 1'b1;
                end else begin
                    state_s = S_POLL_WAIT;
                end
            end
            S_POLL_WAIT: begin
                // A conclusive status outranks a timeout in the same cycle
                if (dec_s == DEC_ERR) begin
                    state_s    = S_FIN;
                    done_s     = 1'b1;
                    done_err_s = 1'b1;
                end else if ((dec_s == DEC_RDY) && (busy_r || two_r)) begin
                    state_s = S_FIN;
                    done_s  = 1'b1;
                end else if (tmo_hit_s) begin
                    state_s    = S_FIN;
                    done_s     = 1'b1;
                    done_err_s = 1'b1;
                end else begin
                    busy_s = busy_r | (dec_s == DEC_BUSY);
                    // Any non-2 status breaks the run of consecutive 2s
                    two_s  = (dec_s == DEC_RDY);
                    gap_s  = 16'd0;
                    if (POLL_GAP == 0) begin
                        state_s = S_POLL_RD;
                        rd_s    = 1'b1;
                    end else begin
                        state_s = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (tmo_hit_s) begin
                    state_s    = S_FIN;
                    done_s     = 1'b1;
                    done_err_s = 1'b1;
                end else if (gap_r == GAP_LAST) begin
                    state_s = S_POLL_RD;
                    rd_s    = 1'b1;
                end else begin
                    gap_s = gap_r + 16'd1;
                end
            end
            S_FIN: begin
                state_s = S_IDLE;
                ready_s = 1'b1;
                busy_s  = 1'b0;
                two_s   = 1'b0;
                gap_s   = 16'd0;
            end
            default: begin
                state_s = S_IDLE;
                ready_s = 1'b1;
                busy_s  = 1'b0;
                two_s   = 1'b0;
                gap_s   = 16'd0;
            end
        endcase
    end

    // State, output and request-field registers with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= S_IDLE;
            ready_r    <= 1'b1;
            done_r     <= 1'b0;
            done_err_r <= 1'b0;
            addr_r     <= 2'd0;
            wr_r       <= 1'b0;
            wdata_r    <= 32'd0;
            rd_r       <= 1'b0;
            busy_r     <= 1'b0;
            two_r      <= 1'b0;
            tmo_r      <= 24'd0;
            gap_r      <= 16'd0;
            req_wr_r   <= 1'b0;
            sect_r     <= 24'd0;
            cnt_r      <= 8'd0;
            base_r     <= 32'd0;
        end else begin
            state_r    <= state_s;
            ready_r    <= ready_s;
            done_r     <= done_s;
            done_err_r <= done_err_s;
            addr_r     <= addr_s;
            wr_r       <= wr_s;
            wdata_r    <= wdata_s;
            rd_r       <= rd_s;
            busy_r     <= busy_s;
            two_r      <= two_s;
            tmo_r      <= tmo_s;
            gap_r      <= gap_s;
            if (hs_s) begin
                req_wr_r <= req_write;
                sect_r   <= req_sector;
                cnt_r    <= req_count;
                base_r   <= req_base;
            end
        end
    end

endmodule

// File: tb/tb_sd_cmd_seq.sv
// Scoreboard bench for sd_cmd_seq. Stimulus pushes expected register writes
// and completions into queues; a monitor pops and compares whenever the DUT
// presents a write strobe or a done pulse. A second instance with a short
// timeout covers the timeout path.
module tb_sd_cmd_seq;
    localparam int POLL_GAP = 4;
    localparam int SPACING  = POLL_GAP + 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid_a, req_valid_b, req_write;
    logic [23:0] req_sector;
    logic [7:0]  req_count;
    logic [31:0] req_base;
    logic        req_ready_a, done_a, done_err_a, avm_write_a, avm_read_a;
    logic [1:0]  avm_address_a;
    logic [31:0] avm_writedata_a;
    logic [31:0] rd_a = 32'd0;
    logic        req_ready_b, done_b, done_err_b, avm_write_b, avm_read_b;
    logic [1:0]  avm_address_b;
    logic [31:0] avm_writedata_b;
    logic [31:0] rd_b = 32'd3;

    always #5 clk = ~clk;

    sd_cmd_seq #(.TIMEOUT_CYCLES(24'd16777215), .POLL_GAP(POLL_GAP)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid_a), .req_ready(req_ready_a),
        .req_write(req_write), .req_sector(req_sector), .req_count(req_count),
        .req_base(req_base), .done(done_a), .done_err(done_err_a),
        .avm_address(avm_address_a), .avm_write(avm_write_a),
        .avm_writedata(avm_writedata_a), .avm_read(avm_read_a), .avm_readdata(rd_a));

    sd_cmd_seq #(.TIMEOUT_CYCLES(24'd100), .POLL_GAP(POLL_GAP)) dut_tmo (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid_b), .req_ready(req_ready_b),
        .req_write(req_write), .req_sector(req_sector), .req_count(req_count),
        .req_base(req_base), .done(done_b), .done_err(done_err_b),
        .avm_address(avm_address_b), .avm_write(avm_write_b),
        .avm_writedata(avm_writedata_b), .avm_read(avm_read_b), .avm_readdata(rd_b));

    typedef struct { int cyc; logic [1:0] addr; logic [31:0] data; } wr_exp_t;
    typedef struct { int lo; int hi; logic err; } done_exp_t;

    wr_exp_t   wr_q[$];
    done_exp_t done_q[$];
    done_exp_t done_qb[$];
    logic [2:0] stat_q[$];
    logic [2:0] stat_dflt = 3'd0;
    int cyc = 0;
    int tests = 0;
    int errs = 0;
    int last_rd = -1;

    always @(posedge clk) cyc <= cyc + 1;

    // Card status model: answers each status read one cycle later
    always @(posedge clk) begin
        if (avm_read_a) begin
            if (stat_q.size() != 0) rd_a <= {29'd0, stat_q.pop_front()};
            else rd_a <= {29'd0, stat_dflt};
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic chk_rng(input string name, input int got, input int lo, input int hi);
        tests++;
        if (got < lo || got > hi) begin
            errs++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, got, lo, hi);
        end
    endtask

    task automatic flag(input string name, input int val);
        tests++;
        errs++;
        $display("FAIL %s: got %0d, expected none (cycle %0d)", name, val, cyc);
    endtask

    // Monitor: compares every strobe and done pulse against the queues
    initial begin
        wr_exp_t e;
        done_exp_t d;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) last_rd = -1;
            if (avm_write_a && avm_read_a) flag("strobe_excl_a", 1);
            if (avm_write_b && avm_read_b) flag("strobe_excl_b", 1);
            if (avm_write_a) begin
                if (wr_q.size() == 0) flag("unexp_write", int'(avm_writedata_a));
                else begin
                    e = wr_q.pop_front();
                    chk("wr_cycle", cyc, e.cyc);
                    chk("wr_addr", {30'd0, avm_address_a}, {30'd0, e.addr});
                    chk("wr_data", avm_writedata_a, e.data);
                end
            end
            if (avm_read_a) begin
                chk("rd_addr", {30'd0, avm_address_a}, 32'd0);
                if (done_q.size() == 0) flag("unexp_read", cyc);
                if (last_rd >= 0) chk("poll_spacing", cyc - last_rd, SPACING);
                last_rd = cyc;
            end
            if (done_a) begin
                last_rd = -1;
                if (done_q.size() == 0) flag("unexp_done", cyc);
                else begin
                    d = done_q.pop_front();
                    chk("done_err", {31'd0, done_err_a}, {31'd0, d.err});
                    chk_rng("done_cycle", cyc, d.lo, d.hi);
                end
            end
            if (avm_read_b && done_qb.size() == 0) flag("unexp_read_b", cyc);
            if (done_b) begin
                if (done_qb.size() == 0) flag("unexp_done_b", cyc);
                else begin
                    d = done_qb.pop_front();
                    chk("done_err_b", {31'd0, done_err_b}, {31'd0, d.err});
                    chk_rng("done_cycle_b", cyc, d.lo, d.hi);
                end
            end
        end
    end

    task automatic wait_ready(input bit b);
        int i;
        for (i = 0; i < 50; i++) begin
            if ((b ? req_ready_b : req_ready_a) === 1'b1) break;
            @(negedge clk);
        end
        chk("ready_wait", {31'd0, (b ? req_ready_b : req_ready_a)}, 32'd1);
    endtask

    task automatic wait_drain(input string name, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (done_q.size() == 0 && done_qb.size() == 0) break;
            @(negedge clk);
        end
        @(negedge clk);
        if (done_q.size() != 0 || done_qb.size() != 0) begin
            flag({name, "_no_done"}, budget);
            done_q.delete();
            done_qb.delete();
        end
        chk({name, "_writes_left"}, wr_q.size(), 32'd0);
        wr_q.delete();
        @(negedge clk);
    endtask

    task automatic run_req(input string name, input bit wr, input logic [23:0] sec,
                           input logic [7:0] cnt, input logic [31:0] base,
                           input int done_off, input bit err, input bit hold);
        int n;
        @(negedge clk);
        wait_ready(1'b0);
        n = cyc;
        req_write   = wr;
        req_sector  = sec;
        req_count   = cnt;
        req_base    = base;
        req_valid_a = 1'b1;
        if (cnt != 8'd0) begin
            wr_q.push_back(wr_exp_t'{n + 1, 2'd0, base});
            wr_q.push_back(wr_exp_t'{n + 2, 2'd1, {8'd0, sec}});
            wr_q.push_back(wr_exp_t'{n + 3, 2'd2, {24'd0, cnt}});
            wr_q.push_back(wr_exp_t'{n + 4, 2'd3, wr ? 32'd3 : 32'd2});
        end
        done_q.push_back(done_exp_t'{n + done_off, n + done_off, err});
        @(negedge clk);
        if (hold) begin
            // Request held and changed while busy must be ignored
            req_write  = ~wr;
            req_sector = ~sec;
            req_count  = cnt + 8'd5;
            req_base   = ~base;
            repeat (3) @(negedge clk);
        end
        req_valid_a = 1'b0;
        wait_drain(name, 1000);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
    end

    initial begin
        int n;
        int i;
        rst_n = 1'b0; req_valid_a = 1'b0; req_valid_b = 1'b0;
        req_write = 1'b0; req_sector = 24'd0; req_count = 8'd0; req_base = 32'd0;
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'd0, req_ready_a}, 32'd1);
        chk("rst_done", {31'd0, done_a}, 32'd0);
        chk("rst_done_err", {31'd0, done_err_a}, 32'd0);
        chk("rst_write", {31'd0, avm_write_a}, 32'd0);
        chk("rst_read", {31'd0, avm_read_a}, 32'd0);
        chk("rst_addr", {30'd0, avm_address_a}, 32'd0);
        chk("rst_wdata", avm_writedata_a, 32'd0);
        chk("rst_ready_b", {31'd0, req_ready_b}, 32'd1);
        rst_n = 1'b1;
        @(negedge clk);

        // Read: 50 busy polls (300 cycles) then status 2 -> done at poll 50
        repeat (50) stat_q.push_back(3'd3);
        stat_dflt = 3'd2;
        run_req("rd_busy", 1'b0, 24'h000010, 8'd2, 32'h00100000, 7 + SPACING * 50, 1'b0, 1'b0);
        // Two immediate status-2 polls; busy from previous request must be gone
        run_req("two_twice", 1'b0, 24'h000020, 8'd4, 32'h00000040, 7 + SPACING, 1'b0, 1'b0);
        // Write: status 4 then 2, request held while busy
        stat_q.push_back(3'd4);
        run_req("wr_busy", 1'b1, 24'h000123, 8'd1, 32'h00200000, 7 + SPACING, 1'b0, 1'b1);
        // Error codes on first poll
        stat_dflt = 3'd0;
        stat_q.push_back(3'd5);
        run_req("st5", 1'b0, 24'h0ABCDE, 8'd8, 32'h12345678, 7, 1'b1, 1'b0);
        stat_q.push_back(3'd1);
        run_req("st1", 1'b1, 24'h000001, 8'd255, 32'h80000000, 7, 1'b1, 1'b0);
        stat_q.push_back(3'd6);
        run_req("st6", 1'b0, 24'hFFFFFF, 8'd3, 32'h00000004, 7, 1'b1, 1'b0);
        stat_q.push_back(3'd7);
        run_req("st7", 1'b1, 24'h00F00F, 8'd9, 32'hCAFEF00D, 7, 1'b1, 1'b0);
        // Status 0 breaks the run of consecutive 2s
        stat_dflt = 3'd2;
        stat_q.push_back(3'd2); stat_q.push_back(3'd0); stat_q.push_back(3'd2);
        run_req("two_broken", 1'b0, 24'h000777, 8'd2, 32'h00003000, 7 + SPACING * 3, 1'b0, 1'b0);
        // Zero count: no bus activity, error the cycle after handshake
        run_req("cnt0", 1'b1, 24'h000055, 8'd0, 32'hDEADBEEF, 1, 1'b1, 1'b0);

        // Timeout on the short-timeout instance, status stuck at 3
        @(negedge clk);
        wait_ready(1'b1);
        n = cyc;
        req_write = 1'b0; req_sector = 24'h000100; req_count = 8'd3; req_base = 32'h00400000;
        req_valid_b = 1'b1;
        done_qb.push_back(done_exp_t'{n + 4 + 100, n + 4 + 100 + POLL_GAP + 2, 1'b1});
        @(negedge clk);
        req_valid_b = 1'b0;
        wait_drain("timeout", 300);

        // Reset during POLL_WAIT: no done, then a fresh request completes
        stat_q.delete();
        stat_dflt = 3'd3;
        @(negedge clk);
        wait_ready(1'b0);
        n = cyc;
        req_write = 1'b0; req_sector = 24'h000200; req_count = 8'd1; req_base = 32'h00500000;
        req_valid_a = 1'b1;
        wr_q.push_back(wr_exp_t'{n + 1, 2'd0, 32'h00500000});
        wr_q.push_back(wr_exp_t'{n + 2, 2'd1, 32'h00000200});
        wr_q.push_back(wr_exp_t'{n + 3, 2'd2, 32'h00000001});
        wr_q.push_back(wr_exp_t'{n + 4, 2'd3, 32'd2});
        done_q.push_back(done_exp_t'{0, 0, 1'b0});
        @(negedge clk);
        req_valid_a = 1'b0;
        for (i = 0; i < 20; i++) begin
            if (avm_read_a === 1'b1) break;
            @(negedge clk);
        end
        chk("rst_reach_poll", {31'd0, avm_read_a}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1 - 1'b1;
        done_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", {31'd0, req_ready_a}, 32'd1);
        chk("post_rst_done", {31'd0, done_a}, 32'd0);
        chk("post_rst_writes_left", wr_q.size(), 32'd0);
        repeat (20) @(negedge clk);
        stat_q.push_back(3'd3);
        stat_dflt = 3'd2;
        run_req("after_rst", 1'b1, 24'h000300, 8'd6, 32'h00600000, 7 + SPACING, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, errs);
        $finish;
    end
endmodule

// File: doc/sd_cmd_seq.md
SD_CMD_SEQ -- requirements
Module: sd_cmd_seq

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 24'd16777215: maximum cycles from command issue to completion before an error is declared.
REQ-002 Parameter POLL_GAP, default 4: idle cycles inserted between consecutive status polls.
REQ-003 clk  input  1  single clock for all logic.
REQ-004 rst_n  input  1  synchronous reset, active-low.
REQ-005 req_valid  input  1  transfer request from the disk controller.
REQ-006 req_ready  output  1  sequencer can accept a request.
REQ-007 req_write  input  1  1 = memory-to-card write (command 3); 0 = card-to-memory read (command 2).
REQ-008 req_sector  input  24  starting sector.
REQ-009 req_count  input  8  sector count.
REQ-010 req_base  input  32  memory base address for the data master.
REQ-011 done  output  1  one-cycle pulse when a request finishes.
REQ-012 done_err  output  1  valid with done; 1 = failed.
REQ-013 avm_address  output  2  register index on the SD driver command/status port.
REQ-014 avm_write  output  1  single-cycle register write strobe; no waitrequest.
REQ-015 avm_writedata  output  32  write data.
REQ-016 avm_read  output  1  single-cycle status read strobe.
REQ-017 avm_readdata  input  32  status; valid exactly one cycle after avm_read.

Function
REQ-018 States: IDLE, WR_BASE, WR_SECT, WR_CNT, WR_CMD, POLL_RD, POLL_WAIT, GAP, FIN.
REQ-019 req_ready SHALL be 1 only in IDLE; handshake = req_valid & req_ready; all req_* fields are latched on handshake.
REQ-020 On handshake with req_count == 0: no bus activity; next cycle done=1, done_err=1; return to IDLE.
REQ-021 Otherwise, on the four cycles after handshake, one write per cycle: address 0 <- base; 1 <- {8'd0, sector}; 2 <- {24'd0, count}; 3 <- 2 (read) or 3 (write).
REQ-022 Cycle after WR_CMD: POLL_RD asserts avm_read for one cycle with avm_address=0; POLL_WAIT samples avm_readdata on the following cycle.
REQ-023 Status decode (low 3 bits): 3 or 4 -> set busy_seen, go to GAP; 0 -> go to GAP; 1 or 5 -> FIN with error; 2 -> FIN success if busy_seen or this is the second consecutive status-2 poll, else GAP.
REQ-024 Status values 6 and 7 SHALL be treated as error.
REQ-025 GAP holds POLL_GAP cycles with no strobes, then returns to POLL_RD.
REQ-026 A 24-bit timeout counter is cleared in WR_CMD and increments every cycle until FIN; reaching TIMEOUT_CYCLES in any poll state -> FIN with error; a status sample in the same cycle takes priority.
REQ-027 FIN: done=1 for exactly one cycle with done_err; next cycle IDLE, req_ready=1; busy_seen and the idle-poll count cleared.
REQ-028 avm_write and avm_read SHALL never be asserted in the same cycle; no strobes outside REQ-021/REQ-022.
REQ-029 req_valid asserted while not in IDLE is ignored; no request queueing.

Reset
REQ-030 With rst_n=0 at a clock edge: state=IDLE; req_ready=1 on exit from reset; done, done_err, avm_read, avm_write=0; avm_address=0; avm_writedata=0; counters and busy_seen=0.
REQ-031 Reset mid-sequence aborts immediately with no further strobes and no done pulse; the driver state is not restored.

Verification
REQ-032 Read req sector=0x000010, count=2, base=0x00100000 -> writes (0,0x00100000),(1,0x10),(2,0x2),(3,0x2) on consecutive cycles; model status 3 for 300 cycles, then 2 -> single done, done_err=0.
REQ-033 Write req count=1 -> command word 3; status 4 then 2 -> done_err=0; poll strobes spaced exactly POLL_GAP+2 cycles apart.
REQ-034 req_count=0 -> zero bus strobes, done=1 with done_err=1 the cycle after handshake.
REQ-035 Status 5 returned on first poll -> done_err=1; status 2 returned immediately twice with no busy seen -> done_err=0 after the second poll.
REQ-036 TIMEOUT_CYCLES=100, status held at 3 -> done_err=1 within 100 + POLL_GAP + 2 cycles of WR_CMD.
REQ-037 rst_n low during POLL_WAIT -> no done pulse; after release req_ready=1 and a new request completes normally.
